// File: rtl/half_adder_pkg.sv
// Shared types and mode constants for the half-adder lane vector.
package half_adder_pkg;

   localparam bit COMB = 1'b0;
   localparam bit REG  = 1'b1;

   typedef struct packed {
      logic c;
      logic s;
   } lane_res_t;

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle for a WIDTH-lane half adder.
interface half_adder_if #(parameter int WIDTH = 1);

   logic             in_valid;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] c_out;
   logic             out_valid;

   modport master (output in_valid, in1, in2, input sum, c_out, out_valid);
   modport slave  (input in_valid, in1, in2, output sum, c_out, out_valid);

endinterface

// File: rtl/half_adder_core.sv
// Single-bit combinational half adder.
module half_adder_core
   import half_adder_pkg::*;
(
   input  logic      a,
   input  logic      b,
   output lane_res_t res
);

   assign res.s = a ^ b;
   assign res.c = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional output register stage.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter bit REGISTERED = REG
) (
   input  logic         clk,
   input  logic         rst_n,
   half_adder_if.slave  bus
);

   localparam int STAGES = (REGISTERED == REG) ? 1 : 0;

   lane_res_t [WIDTH-1:0] res;
   logic      [WIDTH-1:0] sum_c;
   logic      [WIDTH-1:0] cout_c;
   logic      [STAGES:0]  vld_pipe;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      half_adder_core u_core (
         .a   (bus.in1[g]),
         .b   (bus.in2[g]),
         .res (res[g])
      );
      assign sum_c[g]  = res[g].s;
      assign cout_c[g] = res[g].c;
   end

   // Gating with rst_n keeps the combinational valid low during reset too.
   assign vld_pipe[0]   = bus.in_valid & rst_n;
   assign bus.out_valid = vld_pipe[STAGES];

   if (REGISTERED == REG) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] cout_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= '0;
            vld_pipe[1] <= 1'b0;
         end else begin
            vld_pipe[1] <= vld_pipe[0];
            // Operands are ignored while invalid so X inputs cannot leak in.
            if (bus.in_valid) begin
               sum_q  <= sum_c;
               cout_q <= cout_c;
            end
         end
      end

      assign bus.sum   = sum_q;
      assign bus.c_out = cout_q;
   end else begin : g_comb
      assign bus.sum   = sum_c;
      assign bus.c_out = cout_c;
   end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench: 8-lane and 1-lane registered adders plus a 4-lane combinational one.
module tb_half_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   half_adder_if #(.WIDTH(8)) br ();
   half_adder_if #(.WIDTH(1)) b1 ();
   half_adder_if #(.WIDTH(4)) bc ();

   assign b1.in_valid = br.in_valid;
   assign b1.in1      = br.in1[0];
   assign b1.in2      = br.in2[0];

   half_adder #(.WIDTH(8), .REGISTERED(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(br.slave));
   half_adder #(.WIDTH(1), .REGISTERED(1'b1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   half_adder #(.WIDTH(4), .REGISTERED(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc.slave));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [7:0] s;
      logic [7:0] c;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] hs = '0;
   logic [7:0] hc = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected lane results come from the 2-bit arithmetic sum of the operands.
   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      @(negedge clk);
      br.in_valid = v;
      br.in1      = a;
      br.in2      = b;
      if (v) begin
         for (int i = 0; i < 8; i++) begin
            logic [1:0] t;
            t     = {1'b0, a[i]} + {1'b0, b[i]};
            hs[i] = t[0];
            hc[i] = t[1];
         end
      end
      e.v = v;
      e.s = hs;
      e.c = hc;
      sbq.push_back(e);
   endtask

   task automatic collect(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk({tag, "_sbq_empty"}, 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_vld"},  {31'd0, br.out_valid}, {31'd0, e.v});
         chk({tag, "_sum"},  {24'd0, br.sum},       {24'd0, e.s});
         chk({tag, "_cout"}, {24'd0, br.c_out},     {24'd0, e.c});
         chk({tag, "_w1"},   {29'd0, b1.out_valid, b1.c_out, b1.sum}, {29'd0, e.v, e.c[0], e.s[0]});
         chk({tag, "_excl"}, {24'd0, br.sum & br.c_out}, 32'd0);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b);
      drive(v, a, b);
      collect(tag);
   endtask

   initial begin
      logic [3:0] ca [4];
      logic [3:0] cb [4];
      br.in_valid = 1'b0; br.in1 = '0; br.in2 = '0;
      bc.in_valid = 1'b0; bc.in1 = '0; bc.in2 = '0;

      #1;
      chk("por_r", {23'd0, br.out_valid, br.sum}, 32'd0);
      chk("por_rc", {24'd0, br.c_out}, 32'd0);
      chk("por_1", {30'd0, b1.out_valid, b1.sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset mid-phase discards a captured result.
      step("pre_rst", 1'b1, 8'hFF, 8'hFF);
      @(negedge clk);
      br.in_valid = 1'b1; br.in1 = 8'hFF; br.in2 = 8'hFF;
      bc.in_valid = 1'b1; bc.in1 = 4'hF;  bc.in2 = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_sum",  {24'd0, br.sum},   32'd0);
      chk("rst_cout", {24'd0, br.c_out}, 32'd0);
      chk("rst_vld",  {31'd0, br.out_valid}, 32'd0);
      chk("rst_w1",   {30'd0, b1.c_out, b1.out_valid}, 32'd0);
      chk("rst_cvld", {31'd0, bc.out_valid}, 32'd0);
      hs = '0; hc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      bc.in_valid = 1'b0;
      step("rst_rel", 1'b1, 8'hFF, 8'hFF);

      step("tt_00", 1'b1, 8'h00, 8'h00);
      step("tt_10", 1'b1, 8'hFF, 8'h00);
      step("tt_11", 1'b1, 8'hFF, 8'hFF);
      step("tt_01", 1'b1, 8'h00, 8'hFF);

      step("hold_ld", 1'b1, 8'hFF, 8'h00);
      step("hold",    1'b0, 8'hFF, 8'hFF);

      step("lanes", 1'b1, 8'h0C, 8'h0A);
      step("lanes_hi", 1'b1, 8'hC5, 8'hA3);

      // Back-to-back overlapping: drive next before collecting previous.
      drive(1'b1, 8'h3C, 8'h5A);
      fork
         collect("b2b_0");
         drive(1'b1, 8'hF0, 8'h0F);
      join
      collect("b2b_1");

      ca = '{4'h0, 4'hF, 4'hF, 4'h0};
      cb = '{4'h0, 4'h0, 4'hF, 4'hF};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] es, ec;
         for (int k = 0; k < 4; k++) begin
            logic [1:0] t;
            t     = {1'b0, ca[i][k]} + {1'b0, cb[i][k]};
            es[k] = t[0];
            ec[k] = t[1];
         end
         bc.in_valid = i[0];
         bc.in1      = ca[i] ^ {2'b00, i[1:0]};
         bc.in2      = cb[i];
         for (int k = 0; k < 2; k++) begin
            logic [1:0] t;
            t     = {1'b0, bc.in1[k]} + {1'b0, cb[i][k]};
            es[k] = t[0];
            ec[k] = t[1];
         end
         #1;
         chk("comb_sum",  {28'd0, bc.sum},   {28'd0, es});
         chk("comb_cout", {28'd0, bc.c_out}, {28'd0, ec});
         chk("comb_vld",  {31'd0, bc.out_valid}, {31'd0, i[0]});
      end

      for (int n = 0; n < 1000; n++) begin
         step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
